// File: rtl/ram_dp_pkg.sv
// Shared types and default sizing for the dual-port RAM request router.
// Imported by the router top and its response FIFO.
package ram_dp_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 32;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/ram_dp_rsp_fifo.sv
// In-order read-response FIFO with a registered head word.
// Push is never refused: the router's credit counter keeps occupancy within DEPTH.
module ram_dp_rsp_fifo
    import ram_dp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     rd_nxt_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic [DATA_W-1:0] head_nxt_s;
    logic              pop_s;

    // Next pointer/occupancy and next head word, bypassing a push that lands on the head slot.
    always_comb begin
        pop_s      = rsp_valid & rsp_ready;
        rd_nxt_s   = rd_ptr_r + PW'(pop_s);
        cnt_nxt_s  = cnt_r + CW'(push) - CW'(pop_s);
        head_nxt_s = {DATA_W{1'b0}};
        if (cnt_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = {DATA_W{1'b0}};
        end else if (push && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            rd_ptr_r  <= rd_nxt_s;
            wr_ptr_r  <= wr_ptr_r + PW'(push);
            cnt_r     <= cnt_nxt_s;
            rsp_valid <= (cnt_nxt_s != {CW{1'b0}});
            rsp_rdata <= head_nxt_s;
        end
    end

endmodule

// File: rtl/ram_dp_req_router.sv
// Routes single-stream requests onto a true dual-port RAM (low half -> A, high half -> B),
// returns read data in order through a credited FIFO, and can sweep the RAM to zero.
module ram_dp_req_router
    import ram_dp_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              weA,
    output logic              reA,
    output logic [ADDR_W-1:0] addrA,
    output logic [DATA_W-1:0] dinA,
    output logic              weB,
    output logic              reB,
    output logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] dinB,
    input  logic [DATA_W-1:0] doutA,
    input  logic [DATA_W-1:0] doutB
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int KW = ADDR_W - 1;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [KW-1:0]     k_r;
    logic [CW-1:0]     credits_r;
    logic              inflight_r;
    logic              inflight_b_r;
    logic              clr_done_r;
    logic              go_clear_s;
    logic              acc_s;
    logic              acc_rd_s;
    logic              pop_s;
    logic              sweep_end_s;
    logic [DATA_W-1:0] cap_data_s;

    // Handshake, clear entry and sweep termination decode.
    always_comb begin
        clr_busy    = (state_r == CLEAR);
        clr_done    = clr_done_r;
        go_clear_s  = (state_r == RUN) && clr_start && !inflight_r;
        sweep_end_s = (state_r == CLEAR) && (k_r == {KW{1'b1}});
        if (!rst_n || (state_r != RUN) || go_clear_s) begin
            req_ready = 1'b0;
        end else if ((credits_r == CW'(RSP_DEPTH)) && !req_we) begin
            req_ready = 1'b0;
        end else begin
            req_ready = 1'b1;
        end
        acc_s      = req_valid && req_ready;
        acc_rd_s   = acc_s && !req_we;
        pop_s      = rsp_valid && rsp_ready;
        cap_data_s = inflight_b_r ? doutB : doutA;
    end

    // RAM port steering: sweep writes both halves, otherwise the accepted request drives one port.
    always_comb begin
        weA   = 1'b0;
        reA   = 1'b0;
        addrA = {ADDR_W{1'b0}};
        dinA  = {DATA_W{1'b0}};
        weB   = 1'b0;
        reB   = 1'b0;
        addrB = {ADDR_W{1'b0}};
        dinB  = {DATA_W{1'b0}};
        if (!rst_n) begin
            weA = 1'b0;
        end else if (state_r == CLEAR) begin
            weA   = 1'b1;
            addrA = {1'b0, k_r};
            weB   = 1'b1;
            addrB = {1'b1, k_r};
        end else if (acc_s && req_addr[ADDR_W-1]) begin
            weB   = req_we;
            reB   = !req_we;
            addrB = req_addr;
            dinB  = req_wdata;
        end else if (acc_s) begin
            weA   = req_we;
            reA   = !req_we;
            addrA = req_addr;
            dinA  = req_wdata;
        end else begin
            weA = 1'b0;
        end
    end

    // Next-state logic; clr_start is only honoured in RUN with no read outstanding.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN:     state_nxt_s = go_clear_s ? CLEAR : RUN;
            CLEAR:   state_nxt_s = sweep_end_s ? RUN : CLEAR;
            default: state_nxt_s = RUN;
        endcase
    end

    // State, sweep counter, in-flight tracking, credits and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RUN;
            k_r          <= {KW{1'b0}};
            credits_r    <= {CW{1'b0}};
            inflight_r   <= 1'b0;
            inflight_b_r <= 1'b0;
            clr_done_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            k_r          <= (state_r == CLEAR) ? k_r + {{(KW-1){1'b0}}, 1'b1} : {KW{1'b0}};
            inflight_r   <= acc_rd_s;
            inflight_b_r <= acc_rd_s && req_addr[ADDR_W-1];
            clr_done_r   <= sweep_end_s;
            case ({acc_rd_s, pop_s})
                2'b10:   credits_r <= credits_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   credits_r <= credits_r - {{(CW-1){1'b0}}, 1'b1};
                default: credits_r <= credits_r;
            endcase
        end
    end

    ram_dp_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (cap_data_s),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_ram_dp_req_router.sv
// Directed bench: router paired with a behavioural write-first 1024x32 true dual-port RAM.
module tb_ram_dp_req_router;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start, clr_busy, clr_done;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          weA, reA, weB, reB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB, doutA, doutB;

    logic [DW-1:0] mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_dp_req_router dut (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA),
        .weB(weB), .reB(reB), .addrB(addrB), .dinB(dinB),
        .doutA(doutA), .doutB(doutB)
    );

    // Behavioural RAM, one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (weA) mem[addrA] <= dinA;
        if (reA) doutA <= weA ? dinA : mem[addrA];
        if (weB) mem[addrB] <= dinB;
        if (reB) doutB <= weB ? dinB : mem[addrB];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic rd_issue(input logic [AW-1:0] a);
        int t;
        t = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t == 20) check("rd_accept_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [DW-1:0] exp, input string tag);
        int t;
        t = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!rsp_valid && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t == 20) check({tag, "_timeout"}, 32'd0, 32'd1);
        else check(tag, rsp_rdata, exp);
        step();
    endtask

    initial begin
        int acc, got, busy, done, cmax;
        rst_n = 1'b0; clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 10'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // write then read 0x005 on port A
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("s1_weA", {31'd0, weA}, 32'd1);
        check("s1_weB", {31'd0, weB}, 32'd0);
        check("s1_addrA", {22'd0, addrA}, 32'h005);
        step();
        req_we = 1'b0;
        @(negedge clk);
        check("s1_reA", {31'd0, reA}, 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("s1_rsp_c1", {31'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        check("s1_rsp_c2", {31'd0, rsp_valid}, 32'd1);
        check("s1_rdata", rsp_rdata, 32'hDEADBEEF);
        step();

        // read top word through port B
        wr(10'h3FF, 32'h12345678);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h3FF;
        @(negedge clk);
        check("s2_reB", {31'd0, reB}, 32'd1);
        check("s2_addrB", {22'd0, addrB}, 32'h3FF);
        check("s2_reA", {31'd0, reA}, 32'd0);
        step();
        req_valid = 1'b0;
        get_rsp(32'h12345678, "s2_rdata");

        // credit limit with a stalled consumer, then drain in order
        for (int i = 0; i < 6; i++) wr(10'h010 + 10'(i), 32'hA0 + 32'(i));
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready) acc++;
            step();
            req_addr = 10'h010 + 10'(acc);
        end
        check("s3_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        check("s3_ready_low", {31'd0, req_ready}, 32'd0);
        check("s3_head", rsp_rdata, 32'hA0);
        check("s3_credits_full", 32'(dut.credits_r), 32'd4);
        step();
        rsp_ready = 1'b1;
        got = 0; cmax = 0;
        for (int c = 0; c < 40; c++) begin
            if (got == 6) break;
            @(negedge clk);
            if (int'(dut.credits_r) > cmax) cmax = int'(dut.credits_r);
            if (rsp_valid) begin
                check("s3_order", rsp_rdata, 32'hA0 + 32'(got));
                got++;
            end
            if (req_valid && req_ready) acc++;
            step();
            req_addr = 10'h010 + 10'(acc);
            if (acc == 6) req_valid = 1'b0;
        end
        check("s3_got", 32'(got), 32'd6);
        check("s3_acc_total", 32'(acc), 32'd6);
        check("s3_credit_max", 32'(cmax), 32'd4);
        check("s3_credits_end", 32'(dut.credits_r), 32'd0);

        // clear sweep with a response pending across it
        wr(10'h000, 32'h11); wr(10'h1FF, 32'h22); wr(10'h200, 32'h33); wr(10'h3FF, 32'h44);
        rsp_ready = 1'b0;
        rd_issue(10'h005);
        step(); step();
        clr_start = 1'b1;
        @(negedge clk);
        check("s4_ready_on_start", {31'd0, req_ready}, 32'd0);
        step();
        clr_start = 1'b0;
        busy = 0; done = 0;
        for (int c = 0; c < 530; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("s4_sweep_weA", {31'd0, weA}, 32'd1);
                check("s4_sweep_addrB", {22'd0, addrB}, 32'h200);
            end
            if (c == 3) clr_start = 1'b1;
            if (c == 4) clr_start = 1'b0;
            if (c == 5) begin
                check("s4_pending_rdata", rsp_rdata, 32'hDEADBEEF);
                rsp_ready = 1'b1;
            end
            if (c == 6) check("s4_drained", {31'd0, rsp_valid}, 32'd0);
            if (clr_busy) busy++;
            if (clr_done) done++;
            step();
        end
        check("s4_busy_cycles", 32'(busy), 32'd512);
        check("s4_done_pulses", 32'(done), 32'd1);
        rd_issue(10'h000); get_rsp(32'd0, "s4_rd_000");
        rd_issue(10'h1FF); get_rsp(32'd0, "s4_rd_1ff");
        rd_issue(10'h200); get_rsp(32'd0, "s4_rd_200");
        rd_issue(10'h3FF); get_rsp(32'd0, "s4_rd_3ff");

        // reset in the middle of a sweep
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (100) step();
        @(negedge clk);
        check("s5_k100", {22'd0, addrA}, 32'd100);
        #2 rst_n = 1'b0;
        #1;
        check("s5_busy", {31'd0, clr_busy}, 32'd0);
        check("s5_done", {31'd0, clr_done}, 32'd0);
        check("s5_ready", {31'd0, req_ready}, 32'd0);
        check("s5_weA", {31'd0, weA}, 32'd0);
        check("s5_weB", {31'd0, weB}, 32'd0);
        check("s5_addrB", {22'd0, addrB}, 32'd0);
        check("s5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("s5_ready_rel", {31'd0, req_ready}, 32'd1);
        wr(10'h0AB, 32'hCAFEF00D);
        rd_issue(10'h0AB);
        get_rsp(32'hCAFEF00D, "s5_rd_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
